// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte FIFO feeding a UART transmitter over tx_start/din/tx_done_tick
module uart_tx_feeder #(
  parameter int DBIT   = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DBIT-1:0]   wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              busy,
  output logic              tx_start,
  output logic [DBIT-1:0]   tx_din,
  input  logic              tx_done_tick
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [DBIT-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic [0:0]        r_state;
  logic              r_tx_start;
  logic [DBIT-1:0]   r_tx_din;

  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_pop;

  // Full/empty come from the registered count, so a pop in the same cycle never makes room
  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_wr    = wr_en & ~w_full;
  assign w_pop   = (r_state == S_IDLE) & ~w_empty;

  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign busy     = (r_state != S_IDLE) | ~w_empty;
  assign tx_start = r_tx_start;
  assign tx_din   = r_tx_din;

  // Storage array: written on accepted writes only, never reset
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy count and sticky overflow flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Handshake FSM: pop and pulse tx_start from IDLE, then hold in WAIT until the frame completes
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_tx_start <= 1'b0;
      r_tx_din   <= '0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_tx_din   <= r_mem[r_rd_ptr];
            r_tx_start <= 1'b1;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (tx_done_tick) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - self-checking bench for uart_tx_feeder
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       busy;
  logic       tx_start;
  logic [7:0] tx_din;
  logic       tx_done_tick;

  uart_tx_feeder #(.DBIT(8), .ADDR_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .busy         (busy),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a byte queue plus "one frame in flight" flag
  logic [7:0] m_q[$];
  bit         m_inflight = 0;
  bit         m_ovf      = 0;
  bit         m_start    = 0;
  logic [7:0] m_din      = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit we, input logic [7:0] d, input bit dn);
    int  n;
    bit  pop;
    if (!r) begin
      m_q.delete();
      m_inflight = 0;
      m_ovf      = 0;
      m_start    = 0;
      m_din      = 8'h00;
    end else begin
      n   = m_q.size();
      pop = !m_inflight && n > 0;
      if (we && n == 16) m_ovf = 1;
      m_start = 0;
      if (pop) begin
        m_din      = m_q.pop_front();
        m_start    = 1;
        m_inflight = 1;
      end else if (m_inflight && dn) begin
        m_inflight = 0;
      end
      if (we && n < 16) m_q.push_back(d);
    end
  endtask

  task automatic compare_all();
    chk("count",    int'(count),    m_q.size());
    chk("full",     int'(full),     int'(m_q.size() == 16));
    chk("empty",    int'(empty),    int'(m_q.size() == 0));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("busy",     int'(busy),     int'(m_inflight || m_q.size() > 0));
    chk("tx_start", int'(tx_start), int'(m_start));
    chk("tx_din",   int'(tx_din),   int'(m_din));
  endtask

  task automatic cycle(input bit r, input bit we, input logic [7:0] d, input bit dn);
    reset        = r;
    wr_en        = we;
    wr_data      = d;
    tx_done_tick = dn;
    @(posedge clk);
    model_step(r, we, d, dn);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 8'h00, 0);
  endtask

  task automatic done_pulse();
    cycle(1, 0, 8'h00, 1);
  endtask

  typedef struct {
    bit         rst;
    bit         we;
    logic [7:0] d;
    bit         dn;
    int         e_count;
    bit         e_start;
    logic [7:0] e_din;
    bit         e_busy;
    bit         e_empty;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // rst, we, d, dn, count, start, din, busy, empty  (rst=0 means reset asserted)
    vecs[0]  = '{0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1};
    vecs[1]  = '{0, 1, 8'h77, 1, 0, 0, 8'h00, 0, 1};
    vecs[2]  = '{1, 1, 8'hA5, 0, 1, 0, 8'h00, 1, 0};
    vecs[3]  = '{1, 0, 8'h00, 0, 0, 1, 8'hA5, 1, 1};
    vecs[4]  = '{1, 0, 8'h00, 0, 0, 0, 8'hA5, 1, 1};
    vecs[5]  = '{1, 0, 8'h00, 0, 0, 0, 8'hA5, 1, 1};
    vecs[6]  = '{1, 0, 8'h00, 1, 0, 0, 8'hA5, 0, 1};
    vecs[7]  = '{1, 0, 8'h00, 1, 0, 0, 8'hA5, 0, 1};
    vecs[8]  = '{1, 1, 8'h3C, 0, 1, 0, 8'hA5, 1, 0};
    vecs[9]  = '{1, 1, 8'h4D, 0, 1, 1, 8'h3C, 1, 0};
    vecs[10] = '{1, 0, 8'h00, 0, 1, 0, 8'h3C, 1, 0};
    vecs[11] = '{1, 0, 8'h00, 1, 1, 0, 8'h3C, 1, 0};

    // Table-driven single-byte, spurious-done and write-during-pop cases
    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].rst, vecs[i].we, vecs[i].d, vecs[i].dn);
      chk($sformatf("vec%0d_count", i), int'(count),    vecs[i].e_count);
      chk($sformatf("vec%0d_start", i), int'(tx_start), int'(vecs[i].e_start));
      chk($sformatf("vec%0d_din", i),   int'(tx_din),   int'(vecs[i].e_din));
      chk($sformatf("vec%0d_busy", i),  int'(busy),     int'(vecs[i].e_busy));
      chk($sformatf("vec%0d_empty", i), int'(empty),    int'(vecs[i].e_empty));
    end
    idle(3);
    done_pulse();
    idle(3);

    // Burst/order: 0x01..0x05, done 10 cycles after each start
    for (int b = 1; b <= 5; b++) cycle(1, 1, 8'(b), 0);
    for (int k = 0; k < 5; k++) begin
      idle(9);
      done_pulse();
      idle(1);
      chk("burst_start", int'(tx_start), int'(k < 4));
      if (k < 4) chk("burst_din", int'(tx_din), k + 2);
    end
    idle(3);

    // Full and overflow: one byte in flight, then fill 16 slots, then one more write
    cycle(1, 1, 8'h10, 0);
    idle(2);
    for (int b = 8'h11; b <= 8'h20; b++) cycle(1, 1, 8'(b), 0);
    chk("full_count", int'(count), 16);
    chk("full_flag",  int'(full),  1);
    chk("no_ovf_yet", int'(overflow), 0);
    cycle(1, 1, 8'h21, 0);
    chk("ovf_set",    int'(overflow), 1);
    chk("ovf_count",  int'(count), 16);
    // done returns to IDLE; the pop cycle coincides with a write while still full
    done_pulse();
    cycle(1, 1, 8'h22, 0);
    chk("pop_full_count", int'(count), 15);
    chk("pop_full_din",   int'(tx_din), 8'h11);
    for (int k = 0; k < 16; k++) begin
      idle(3);
      done_pulse();
    end
    idle(3);
    chk("drained_empty", int'(empty), 1);
    chk("ovf_sticky",    int'(overflow), 1);

    // Reset mid-operation with bytes queued and one in flight, then a late done
    cycle(0, 0, 8'h00, 0);
    cycle(1, 1, 8'hB1, 0);
    cycle(1, 1, 8'hB2, 0);
    cycle(1, 1, 8'hB3, 0);
    cycle(1, 1, 8'hB4, 0);
    cycle(0, 0, 8'h00, 0);
    chk("rst_count", int'(count), 0);
    chk("rst_ovf",   int'(overflow), 0);
    chk("rst_din",   int'(tx_din), 0);
    done_pulse();
    idle(2);
    chk("late_done_nostart", int'(tx_start), 0);
    cycle(1, 1, 8'h5A, 0);
    cycle(1, 0, 8'h00, 0);
    chk("post_rst_din", int'(tx_din), 8'h5A);
    done_pulse();
    idle(2);

    // Randomized traffic with occasional resets; also exercises pointer wrap
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 99) < 45),
            8'($urandom),
            ($urandom_range(0, 99) < 25));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // tx_start must never stay high two cycles in a row
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (prev_start && tx_start) begin
      n_tests++;
      n_fail++;
      $display("FAIL start_twice @%0t: got 1 expected 0", $time);
    end
    prev_start <= tx_start;
  end

endmodule
